zxw_dmem_req_ctrl: RTL

Request sequencer sitting directly upstream of the direct-mapped/CAM data-cache controller (zxw_cram_v). It accepts CPU load/store requests through a valid/ready handshake and buffers them in a small FIFO. It presents one request at a time on the cache's DM_address/datain/ram_wr inputs, holding them stable while the cache raises stall_flg during line fills or write misses. It returns load data, or a store acknowledge, with a one-cycle rsp_valid pulse, and keeps stall/request statistics.

---
 rtl/zxw_dmem_req_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/zxw_dmem_req_ctrl.sv
// zxw_dmem_req_ctrl: CPU load/store request sequencer in front of the
// zxw_cram_v data cache. Requests are buffered in a small FIFO, issued one
// at a time and held stable while the cache stalls. Each request completes
// with a one-cycle response pulse. Stall and completion counts saturate.
module zxw_dmem_req_ctrl #(
  parameter int DEPTH  = 2,
  parameter int SETTLE = 2,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_wr,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic              cpu_rsp_wr,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic [ADDR_W-1:0] DM_address,
  output logic [DATA_W-1:0] datain,
  output logic              ram_wr,
  input  logic              stall_flg,
  input  logic [DATA_W-1:0] DM_out,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  req_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]        state;
  logic [SW-1:0]     settle_cnt;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              q_wr   [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              push;
  logic              pop;

  assign cpu_req_ready = (count < CW'(DEPTH));
  assign push          = cpu_req_valid & cpu_req_ready;
  // Completion edge: settled, cache not stalling.
  assign pop           = (state == WAIT) && (settle_cnt == '0) && !stall_flg;
  assign busy          = (state != IDLE) || (count != '0);

  // FIFO payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge Clock) begin
    if (push) begin
      q_addr[wr_ptr] <= cpu_req_addr;
      q_data[wr_ptr] <= cpu_req_wdata;
      q_wr[wr_ptr]   <= cpu_req_wr;
    end
  end

  // FIFO pointers and occupancy; push and pop on the same edge cancel out.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue/wait/gap sequencer driving the cache and the response port.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      DM_address    <= '0;
      datain        <= '0;
      ram_wr        <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_wr    <= 1'b0;
      cpu_rsp_data  <= '0;
      stall_cycles  <= '0;
      req_done      <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            DM_address <= q_addr[rd_ptr];
            datain     <= q_data[rd_ptr];
            ram_wr     <= q_wr[rd_ptr];
            settle_cnt <= SW'(SETTLE);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else if (stall_flg) begin
            if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
          end else begin
            cpu_rsp_data  <= DM_out;
            cpu_rsp_wr    <= ram_wr;
            cpu_rsp_valid <= 1'b1;
            if (req_done != '1) req_done <= req_done + CNT_W'(1);
            ram_wr        <= 1'b0;
            state         <= GAP;
          end
        end
        GAP: begin
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
